// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matmul sequencer.
// Optional result saturation is enabled by defining MATMUL_SAT_EN.
package matmul_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned FAW      = 5;
    localparam int unsigned WAW      = 4;
    localparam int unsigned ACC_W    = 2*DW + $clog2(N);
    localparam int unsigned NN       = N*N;
    localparam int unsigned RES_BASE = NN;
    localparam int unsigned IW       = $clog2(N);
    localparam int unsigned CW       = $clog2(NN+1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DRAIN = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/matmul_mac.sv
// Clear/enable multiply-accumulate with a truncating output stage,
// or a saturating one when MATMUL_SAT_EN is defined.
module matmul_mac
    import matmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res_next_c
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [2*DW-1:0]  prod;

    always_comb begin
        prod  = (2*DW)'(a) * (2*DW)'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Result is taken from the next accumulator value so the writeback can be registered on entry to WR.
    always_comb begin
`ifdef MATMUL_SAT_EN
        res_next_c = (|acc_d[ACC_W-1:DW]) ? {DW{1'b1}} : acc_d[DW-1:0];
`else
        res_next_c = acc_d[DW-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Loads F and W into external RAMs, then computes C = F x W on one MAC,
// writing C above the operands in feature RAM and streaming it on port_O.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           startSignal,
    input  logic [DW-1:0]  port_A,
    input  logic [DW-1:0]  port_W,
    input  logic           write_enable_A,
    input  logic           write_enable_W,
    output logic [FAW-1:0] fm_addr,
    output logic           fm_we,
    output logic [DW-1:0]  fm_wdata,
    input  logic [DW-1:0]  fm_rdata,
    output logic [WAW-1:0] wm_addr,
    output logic           wm_we,
    output logic [DW-1:0]  wm_wdata,
    input  logic [DW-1:0]  wm_rdata,
    output logic [DW-1:0]  port_O,
    output logic           o_valid,
    output logic           busy,
    output logic           done
);

    state_e         state_q, state_d;
    logic [CW-1:0]  a_cnt_q, a_cnt_d;
    logic [CW-1:0]  w_cnt_q, w_cnt_d;
    logic [IW-1:0]  r_q, r_d;
    logic [IW-1:0]  c_q, c_d;
    logic [IW-1:0]  k_q, k_d;

    logic [FAW-1:0] fm_addr_q, fm_addr_d;
    logic           fm_we_q, fm_we_d;
    logic [DW-1:0]  fm_wdata_q, fm_wdata_d;
    logic [WAW-1:0] wm_addr_q, wm_addr_d;
    logic           wm_we_q, wm_we_d;
    logic [DW-1:0]  wm_wdata_q, wm_wdata_d;
    logic [DW-1:0]  port_o_q, port_o_d;
    logic           o_valid_q, o_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           mac_clr;
    logic           mac_en;
    logic [DW-1:0]  res_c;

    matmul_mac u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr        (mac_clr),
        .en         (mac_en),
        .a          (fm_rdata),
        .b          (wm_rdata),
        .res_next_c (res_c)
    );

    always_comb begin
        state_d    = state_q;
        a_cnt_d    = a_cnt_q;
        w_cnt_d    = w_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        fm_addr_d  = '0;
        fm_we_d    = 1'b0;
        fm_wdata_d = '0;
        wm_addr_d  = '0;
        wm_we_d    = 1'b0;
        wm_wdata_d = '0;
        port_o_d   = port_o_q;
        o_valid_d  = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (write_enable_A && (a_cnt_q < CW'(NN))) begin
                    fm_we_d    = 1'b1;
                    fm_addr_d  = FAW'(a_cnt_q);
                    fm_wdata_d = port_A;
                    a_cnt_d    = a_cnt_q + CW'(1);
                end
                if (write_enable_W && (w_cnt_q < CW'(NN))) begin
                    wm_we_d    = 1'b1;
                    wm_addr_d  = WAW'(w_cnt_q);
                    wm_wdata_d = port_W;
                    w_cnt_d    = w_cnt_q + CW'(1);
                end
                // Start is judged on the counts before this cycle's loads land.
                if (startSignal && (a_cnt_q == CW'(NN)) && (w_cnt_q == CW'(NN))) begin
                    state_d = RD;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            RD: begin
                mac_clr = (k_q == '0);
                mac_en  = (k_q != '0);
                if (k_q == IW'(N-1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            DRAIN: begin
                mac_en  = 1'b1;
                state_d = WR;
            end
            WR: begin
                if (c_q == IW'(N-1)) begin
                    c_d = '0;
                    if (r_q == IW'(N-1)) begin
                        r_d     = '0;
                        state_d = DONE;
                    end else begin
                        r_d     = r_q + IW'(1);
                        state_d = RD;
                    end
                end else begin
                    c_d     = c_q + IW'(1);
                    state_d = RD;
                end
            end
            DONE: begin
                if (!startSignal) begin
                    state_d = IDLE;
                    a_cnt_d = '0;
                    w_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the upcoming state so they line up with it once registered.
        case (state_d)
            RD: begin
                fm_addr_d = FAW'(r_d) * FAW'(N) + FAW'(k_d);
                wm_addr_d = WAW'(k_d) * WAW'(N) + WAW'(c_d);
            end
            WR: begin
                fm_we_d    = 1'b1;
                fm_addr_d  = FAW'(RES_BASE) + FAW'(r_d) * FAW'(N) + FAW'(c_d);
                fm_wdata_d = res_c;
                port_o_d   = res_c;
                o_valid_d  = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d == RD) || (state_d == DRAIN) || (state_d == WR);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_cnt_q    <= '0;
            w_cnt_q    <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            fm_addr_q  <= '0;
            fm_we_q    <= 1'b0;
            fm_wdata_q <= '0;
            wm_addr_q  <= '0;
            wm_we_q    <= 1'b0;
            wm_wdata_q <= '0;
            port_o_q   <= '0;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_cnt_q    <= a_cnt_d;
            w_cnt_q    <= w_cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            fm_addr_q  <= fm_addr_d;
            fm_we_q    <= fm_we_d;
            fm_wdata_q <= fm_wdata_d;
            wm_addr_q  <= wm_addr_d;
            wm_we_q    <= wm_we_d;
            wm_wdata_q <= wm_wdata_d;
            port_o_q   <= port_o_d;
            o_valid_q  <= o_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fm_addr  = fm_addr_q;
    assign fm_we    = fm_we_q;
    assign fm_wdata = fm_wdata_q;
    assign wm_addr  = wm_addr_q;
    assign wm_we    = wm_we_q;
    assign wm_wdata = wm_wdata_q;
    assign port_O   = port_o_q;
    assign o_valid  = o_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: RAM models, table-driven golden runs, random runs
// against an arithmetic matrix model, and load/start/reset corner sequences.
`timescale 1ns/1ps
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  port_a = '0;
    logic [DW-1:0]  port_w = '0;
    logic           we_a = 1'b0;
    logic           we_w = 1'b0;
    logic [FAW-1:0] fm_addr;
    logic           fm_we;
    logic [DW-1:0]  fm_wdata;
    logic [DW-1:0]  fm_rdata;
    logic [WAW-1:0] wm_addr;
    logic           wm_we;
    logic [DW-1:0]  wm_wdata;
    logic [DW-1:0]  wm_rdata;
    logic [DW-1:0]  port_O;
    logic           o_valid;
    logic           busy;
    logic           done;

    matmul_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .startSignal    (start),
        .port_A         (port_a),
        .port_W         (port_w),
        .write_enable_A (we_a),
        .write_enable_W (we_w),
        .fm_addr        (fm_addr),
        .fm_we          (fm_we),
        .fm_wdata       (fm_wdata),
        .fm_rdata       (fm_rdata),
        .wm_addr        (wm_addr),
        .wm_we          (wm_we),
        .wm_wdata       (wm_wdata),
        .wm_rdata       (wm_rdata),
        .port_O         (port_O),
        .o_valid        (o_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fm_mem [2*NN];
    logic [DW-1:0] wm_mem [NN];

    // Synchronous-read single-port RAMs.
    always @(posedge clk) begin
        if (fm_we) fm_mem[fm_addr] <= fm_wdata;
        if (wm_we) wm_mem[wm_addr] <= wm_wdata;
        fm_rdata <= fm_mem[fm_addr];
        wm_rdata <= wm_mem[wm_addr];
    end

    typedef struct packed {
        logic [NN*DW-1:0] f;
        logic [NN*DW-1:0] w;
        logic [NN*DW-1:0] c;
    } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            fwe_cnt;
    int            wwe_cnt;
    logic [DW-1:0] fa [NN];
    logic [DW-1:0] wa [NN];
    logic [DW-1:0] exp_c [NN];

    task automatic check(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] model(input int i, input int j);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(fa[i*N+k]) * int'(wa[k*N+j]);
`ifdef MATMUL_SAT_EN
        return (s > 255) ? 8'd255 : 8'(s);
`else
        return 8'(s);
`endif
    endfunction

    task automatic rand_mats(input bit big);
        for (int i = 0; i < NN; i++) begin
            fa[i] = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
            wa[i] = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
        end
        for (int i = 0; i < NN; i++) exp_c[i] = model(i / N, i % N);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; we_a = 1'b0; we_w = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int na, input int nw);
        int nmax;
        nmax = (na > nw) ? na : nw;
        for (int i = 0; i < nmax + 2; i++) begin
            @(negedge clk);
            if (fm_we) fwe_cnt++;
            if (wm_we) wwe_cnt++;
            we_a   = (i < na);
            we_w   = (i < nw);
            port_a = (i < NN) ? fa[i] : 8'($urandom);
            port_w = (i < NN) ? wa[i] : 8'($urandom);
        end
    endtask

    // Follow one computation to DONE, throwing load strobes at the DUT while it is busy.
    task automatic collect(input string name, output int wait_cyc);
        int  t, nv, stray, done_at, bad_mem;
        bit  seen;
        wait_cyc = -1; t = 0; nv = 0; stray = 0; done_at = -1; seen = 1'b0; bad_mem = 0;
        for (int cyc = 1; cyc <= 400 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (!seen && busy) begin
                seen = 1'b1;
                wait_cyc = cyc;
            end
            if (seen) begin
                if (o_valid) begin
                    if (nv < NN) begin
                        check({name, " port_O"}, int'(port_O), int'(exp_c[nv]));
                        check({name, " wb_addr"}, int'(fm_addr), NN + nv);
                    end
                    nv++;
                end
                if ((fm_we && !o_valid) || wm_we) stray++;
                if (done) done_at = t;
                t++;
                if (busy) begin
                    we_a   = 1'($urandom);
                    we_w   = 1'($urandom);
                    port_a = 8'($urandom);
                    port_w = 8'($urandom);
                end else begin
                    we_a = 1'b0;
                    we_w = 1'b0;
                end
            end
        end
        we_a = 1'b0;
        we_w = 1'b0;
        check({name, " n_valid"}, nv, NN);
        check({name, " stray_writes"}, stray, 0);
        check({name, " done_latency"}, done_at, NN * (N + 2));
        for (int i = 0; i < NN; i++) if (fm_mem[NN+i] !== exp_c[i]) bad_mem++;
        check({name, " result_ram"}, bad_mem, 0);
    endtask

    task automatic finish_run(input string name);
        int held;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done && !busy) held++;
        end
        check({name, " done_held"}, held, 3);
        start = 1'b0;
        @(negedge clk);
        check({name, " done_clear"}, int'({done, busy}), 0);
    endtask

    task automatic run_test(input string name, input int extra_a);
        int wc;
        fwe_cnt = 0;
        wwe_cnt = 0;
        load(NN + extra_a, NN);
        check({name, " load_fm_we"}, fwe_cnt, NN);
        check({name, " load_wm_we"}, wwe_cnt, NN);
        start = 1'b1;
        collect(name, wc);
        check({name, " start_lat"}, wc, 1);
        finish_run(name);
    endtask

    initial begin
        vec_t          tbl [2];
        logic [DW-1:0] wb [NN];
        logic [DW-1:0] crow [N];
        int            cnt;
        int            wc;
        bit            seen;

        wb   = '{8'd4, 8'd0, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd0,
                 8'd4, 8'd3, 8'd0, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
        crow = '{8'd40, 8'd27, 8'd14, 8'd8};
        for (int i = 0; i < NN; i++) begin
            tbl[0].f[i*DW +: DW] = 8'(i % N + 1);
            tbl[0].w[i*DW +: DW] = wb[i];
            tbl[0].c[i*DW +: DW] = crow[i % N];
            tbl[1].f[i*DW +: DW] = 8'd255;
            tbl[1].w[i*DW +: DW] = 8'd255;
`ifdef MATMUL_SAT_EN
            tbl[1].c[i*DW +: DW] = 8'd255;
`else
            tbl[1].c[i*DW +: DW] = 8'd4;
`endif
        end

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset ctrl", int'({busy, done, o_valid, fm_we, wm_we}), 0);
        check("reset port_O", int'(port_O), 0);
        check("reset addrs", int'({fm_addr, wm_addr}), 0);
        check("reset state", int'(dut.state_q), int'(IDLE));
        do_reset();

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < NN; i++) begin
                fa[i]    = tbl[t].f[i*DW +: DW];
                wa[i]    = tbl[t].w[i*DW +: DW];
                exp_c[i] = tbl[t].c[i*DW +: DW];
            end
            run_test((t == 0) ? "baseline" : "width", 0);
        end

        // Counters are cleared on leaving DONE, so start alone must not run.
        start = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("no_reload busy", cnt, 0);
        start = 1'b0;

        rand_mats(1'b0);
        run_test("overfill", 2);

        // Premature start: one F element short.
        do_reset();
        rand_mats(1'b0);
        load(NN - 1, NN);
        start = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("premature busy", cnt, 0);
        we_a   = 1'b1;
        port_a = fa[NN-1];
        @(negedge clk);
        we_a = 1'b0;
        check("premature last_load", int'(busy), 0);
        collect("premature", wc);
        check("premature start_lat", wc, 1);
        finish_run("premature");

        // Reset during RD of element (2,1).
        rand_mats(1'b0);
        load(NN, NN);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("midrst started", int'(seen), 1);
        repeat ((2*N + 1) * (N + 2) + 2) @(negedge clk);
        check("midrst in_rd", int'(dut.state_q), int'(RD));
        #2 rst = 1'b1;
        #1;
        check("midrst ctrl", int'({busy, o_valid, done, fm_we}), 0);
        check("midrst state", int'(dut.state_q), int'(IDLE));
        check("midrst counters", int'(dut.a_cnt_q) + int'(dut.w_cnt_q) + int'(dut.r_q) + int'(dut.c_q) + int'(dut.k_q), 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rand_mats(1'b0);
        run_test("post_rst", 0);

        for (int t = 0; t < 3; t++) begin
            rand_mats(t == 2);
            run_test($sformatf("random%0d", t), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller for the feature/weight memory datapath: sequences serial loading of two N×N 8-bit matrices, then runs C = F × W on one multiply-accumulate unit.
- Writes each C element back into the feature memory above the operand region and streams it on port_O.
- Sits between the stimulus/host ports and two external synchronous-read single-port RAMs.

Parameters:
- N, 4, matrix dimension.
- DW, 8, element width.
- FAW, 5, feature memory address width; must hold 2*N*N entries.
- WAW, 4, weight memory address width; must hold N*N entries.
- ACC_W, 2*DW+$clog2(N) = 18, accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- startSignal  in  1  level start request
- port_A  in  DW  feature element to load
- port_W  in  DW  weight element to load
- write_enable_A  in  1  load port_A this cycle
- write_enable_W  in  1  load port_W this cycle
- fm_addr  out  FAW  feature RAM address
- fm_we  out  1  feature RAM write enable
- fm_wdata  out  DW  feature RAM write data
- fm_rdata  in  DW  feature RAM read data; valid 1 cycle after address
- wm_addr  out  WAW  weight RAM address
- wm_we  out  1  weight RAM write enable
- wm_wdata  out  DW  weight RAM write data
- wm_rdata  in  DW  weight RAM read data; valid 1 cycle after address
- port_O  out  DW  result element
- o_valid  out  1  port_O valid pulse
- busy  out  1  high in RD/DRAIN/WR
- done  out  1  high in DONE

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; load counters a_cnt/w_cnt, indices r/c/k and acc all 0. Reset mid-operation aborts immediately. RAM contents are untouched.
- States: IDLE, RD, DRAIN, WR, DONE.
- IDLE loading:
  - write_enable_A with a_cnt<N*N: fm_we=1, fm_addr=a_cnt, fm_wdata=port_A, then a_cnt++.
  - write_enable_W is handled the same way on the W port with w_cnt.
  - A and W writes may occur in the same cycle.
  - Writes with the counter already at N*N, or outside IDLE, are dropped with no RAM strobe.
- IDLE→RD: startSignal=1 and a_cnt==N*N and w_cnt==N*N. Otherwise start is ignored. Load strobes in that same cycle are honoured and start waits.
- RD, N cycles (k=0..N-1):
  - fm_addr=r*N+k, wm_addr=k*N+c, no writes.
  - acc clears on the first RD cycle of each element.
  - From the second RD cycle onward, acc += fm_rdata*wm_rdata (product of the previous cycle's address).
- DRAIN, 1 cycle: accumulates the final product.
- WR, 1 cycle:
  - fm_we=1, fm_addr=N*N+r*N+c, fm_wdata=result; port_O=result, o_valid=1.
  - Then c++; on c wrap, r++.
  - After r=c=N-1, go to DONE; otherwise back to RD.
- Latency: N+2 cycles per element, N*N*(N+2) = 96 cycles for N=4, counted from the first RD cycle to the last WR cycle inclusive.
- Arithmetic: products unsigned 2*DW, accumulated in ACC_W with no overflow possible. Result is acc[DW-1:0] (truncation).
- DONE: held while startSignal=1. On startSignal=0, go to IDLE and clear a_cnt/w_cnt, so the next run requires a full reload.
- startSignal, write_enable_A and write_enable_W are ignored while busy.

Optional Feature:
- MATMUL_SAT_EN defined: result = (acc > 2^DW-1) ? 2^DW-1 : acc[DW-1:0].
- Undefined: truncation.
- Timing is identical in both cases.

Decomposition:
- Shared package matmul_pkg: state enum (IDLE, RD, DRAIN, WR, DONE), default N/DW, ACC_W derivation, and the result-region base N*N.
- One natural sub-module: matmul_mac (clear/enable multiply-accumulate with DW inputs, ACC_W accumulator, truncate/saturate output stage).
- Address generation and FSM stay in the top module.

Test Plan:
- Baseline product:
  - Stimulus: load W rows [4,0,2,1],[4,3,2,0],[4,3,0,1],[4,3,2,1] and F rows all [1,2,3,4]; raise startSignal.
  - Required response: 16 o_valid pulses, each row reading 40 27 14 8. feature RAM[16..31] holds the same values. done is asserted 96 cycles after the first RD cycle.
- Width behaviour:
  - Stimulus: all F and W = 255.
  - Required response: every result = 4 without MATMUL_SAT_EN; 255 with MATMUL_SAT_EN.
- Premature start:
  - Stimulus: load 15 F elements and 16 W elements, then assert startSignal.
  - Required response: no RD; busy stays 0.
  - Stimulus: load the 16th F element.
  - Required response: compute starts on the next start-sampled cycle.
- Overfill and busy writes:
  - Stimulus: 18 write_enable_A strobes; then further write strobes while busy.
  - Required response: only 16 fm_we strobes during load; no RAM write strobes while busy other than WR writebacks.
- Reset mid-operation:
  - Stimulus: assert rst during RD of element (2,1).
  - Required response: busy=0, o_valid=0, state IDLE, counters 0 immediately, with no clk edge needed. A full reload plus start then yields correct results.
- Rerun:
  - Stimulus: after DONE, drop startSignal, reload new matrices, restart.
  - Required response: DONE→IDLE occurs only on startSignal=0; the second result matches a golden model.
